// File: rtl/frame_buffer_arbiter_if.sv
// frame_buffer_arbiter_if: request/grant/read-return bundle between the three frame-buffer clients and the arbiter
interface frame_buffer_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    logic              cam_req;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_wdata;
    logic              cam_gnt;
    logic              cam_err;
    logic              sob_req;
    logic [ADDR_W-1:0] sob_addr;
    logic              sob_gnt;
    logic              sob_rvalid;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output cam_req, cam_addr, cam_wdata, sob_req, sob_addr, vga_req, vga_addr,
        input  cam_gnt, cam_err, sob_gnt, sob_rvalid, vga_gnt, vga_rvalid, rdata
    );

    modport slave (
        input  cam_req, cam_addr, cam_wdata, sob_req, sob_addr, vga_req, vga_addr,
        output cam_gnt, cam_err, sob_gnt, sob_rvalid, vga_gnt, vga_rvalid, rdata
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares one single-port 150x150 frame-buffer RAM between cam writer, Sobel reader and VGA reader
// Optional feature macro SOB_STARVE_GUARD_EN: sob wait counter that overrides vga priority after MAX_WAIT cycles.
module frame_buffer_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 22500
`ifdef SOB_STARVE_GUARD_EN
    ,
    parameter int MAX_WAIT = 15
`endif
) (
    input  logic                  clk_50,
    input  logic                  rst_n,
    frame_buffer_arbiter_if.slave bus,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH);

    logic rr_sob;
    logic force_sob;
    logic cam_oor, sob_oor, vga_oor;
    logic sob_rd, vga_rd, rd_zero, rd_zero_q;

    assign cam_oor = bus.cam_addr >= LIM;
    assign sob_oor = bus.sob_addr >= LIM;
    assign vga_oor = bus.vga_addr >= LIM;

`ifdef SOB_STARVE_GUARD_EN
    logic [3:0] wait_cnt;
    assign force_sob = bus.sob_req && wait_cnt == 4'(MAX_WAIT);
    // count cycles sob is left waiting; a grant or a dropped request restarts the count
    always_ff @(posedge clk_50) begin
        if (!rst_n || !bus.sob_req || bus.sob_gnt) wait_cnt <= '0;
        else wait_cnt <= wait_cnt + 4'd1;
    end
`else
    assign force_sob = 1'b0;
`endif

    // vga first unless sob is starving, then round-robin between cam and sob; nothing granted in reset
    always_comb begin
        bus.vga_gnt = rst_n && bus.vga_req && !force_sob;
        bus.sob_gnt = rst_n && bus.sob_req && (force_sob || (!bus.vga_req && (!bus.cam_req || rr_sob)));
        bus.cam_gnt = rst_n && bus.cam_req && !force_sob && !bus.vga_req && (!bus.sob_req || !rr_sob);
    end

    // round-robin pointer moves to the other client only on cam/sob grants
    always_ff @(posedge clk_50) begin
        if (!rst_n) rr_sob <= 1'b0;
        else if (bus.cam_gnt || bus.sob_gnt) rr_sob <= bus.cam_gnt;
    end

    // stage 1: drive the winner onto the RAM port and tag the read for its return
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            bus.cam_err <= 1'b0;
            sob_rd      <= 1'b0;
            vga_rd      <= 1'b0;
            rd_zero     <= 1'b0;
        end else begin
            if (bus.vga_gnt) mem_addr <= bus.vga_addr;
            else if (bus.sob_gnt) mem_addr <= bus.sob_addr;
            else if (bus.cam_gnt) mem_addr <= bus.cam_addr;
            if (bus.cam_gnt) mem_wdata <= bus.cam_wdata;
            mem_we      <= bus.cam_gnt && !cam_oor;
            bus.cam_err <= bus.cam_gnt && cam_oor;
            sob_rd      <= bus.sob_gnt;
            vga_rd      <= bus.vga_gnt;
            rd_zero     <= (bus.sob_gnt && sob_oor) || (bus.vga_gnt && vga_oor);
        end
    end

    // stage 2: RAM data is out now, so flag it valid for whichever reader issued it
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            bus.sob_rvalid <= 1'b0;
            bus.vga_rvalid <= 1'b0;
            rd_zero_q      <= 1'b0;
        end else begin
            bus.sob_rvalid <= sob_rd;
            bus.vga_rvalid <= vga_rd;
            rd_zero_q      <= rd_zero;
        end
    end

    // out-of-range reads return zero instead of whatever the RAM decoded
    always_comb begin
        bus.rdata = ((bus.sob_rvalid || bus.vga_rvalid) && !rd_zero_q) ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed and randomized checks of frame_buffer_arbiter against a transaction-level model
module tb_frame_buffer_arbiter;
    localparam int DEPTH = 22500;

    logic        clk_50 = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] ram [0:32767];

    frame_buffer_arbiter_if bus ();

    frame_buffer_arbiter dut (
        .clk_50   (clk_50),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk_50 = ~clk_50;

    // RAM macro stand-in: preloaded pattern, one-cycle synchronous read
    always @(posedge clk_50) begin
        if (!rst_n) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 16'(i) ^ 16'hA5A5;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    logic [15:0] mref [0:32767];
    int          total = 0;
    int          bad = 0;
    logic        turn_sob;
    int          starve;
    logic        e_we, e_err;
    logic [14:0] e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_rv1, e_rv2;
    logic [15:0] e_rd1, e_rd2;
    int          exp_g;
    int          dut_g;
    int          exp_seq [7] = '{1, 2, 3, 1, 2, 1, 2};
    int          nsob;
    int          first_at;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 15'(22496 + $urandom_range(0, 8)) : 15'($urandom_range(0, 63));
    endfunction

    // one clock: predict the winner, compare everything, then retire the transaction into the model
    task automatic tick();
        logic        frc;
        logic [14:0] ra;
        @(negedge clk_50);
        frc = 1'b0;
`ifdef SOB_STARVE_GUARD_EN
        frc = bus.sob_req && starve == 15;
`endif
        if (frc) exp_g = 2;
        else if (bus.vga_req) exp_g = 3;
        else if (bus.cam_req && bus.sob_req) exp_g = turn_sob ? 2 : 1;
        else exp_g = bus.cam_req ? 1 : (bus.sob_req ? 2 : 0);
        dut_g = bus.vga_gnt ? 3 : (bus.sob_gnt ? 2 : (bus.cam_gnt ? 1 : 0));
        check("cam_gnt", 32'(bus.cam_gnt), 32'(exp_g == 1));
        check("sob_gnt", 32'(bus.sob_gnt), 32'(exp_g == 2));
        check("vga_gnt", 32'(bus.vga_gnt), 32'(exp_g == 3));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        check("cam_err", 32'(bus.cam_err), 32'(e_err));
        check("sob_rvalid", 32'(bus.sob_rvalid), 32'(e_rv2[0]));
        check("vga_rvalid", 32'(bus.vga_rvalid), 32'(e_rv2[1]));
        if (e_rv2 != 2'b00) check("rdata", 32'(bus.rdata), 32'(e_rd2));
        starve = (bus.sob_req && exp_g != 2) ? starve + 1 : 0;
        if (exp_g == 1 || exp_g == 2) turn_sob = (exp_g == 1);
        e_rv2 = e_rv1;
        e_rd2 = e_rd1;
        e_rv1 = {exp_g == 3, exp_g == 2};
        e_we = 1'b0;
        e_err = 1'b0;
        if (exp_g != 0) begin
            ra = (exp_g == 1) ? bus.cam_addr : ((exp_g == 2) ? bus.sob_addr : bus.vga_addr);
            e_addr = ra;
            e_rd1 = (int'(ra) < DEPTH) ? mref[ra] : 16'h0000;
            if (exp_g == 1) begin
                e_wdata = bus.cam_wdata;
                e_we = int'(ra) < DEPTH;
                e_err = !e_we;
                if (e_we) mref[ra] = bus.cam_wdata;
            end
        end
        @(posedge clk_50);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mref[i] = 16'(i) ^ 16'hA5A5;
        bus.cam_req = 1'b1;
        bus.sob_req = 1'b1;
        bus.vga_req = 1'b1;
        bus.cam_addr = 15'd1;
        bus.cam_wdata = 16'h1111;
        bus.sob_addr = 15'd2;
        bus.vga_addr = 15'd3;
        repeat (3) begin
            @(negedge clk_50);
            check("rst_gnt", 32'({bus.cam_gnt, bus.sob_gnt, bus.vga_gnt}), 32'd0);
            check("rst_out", 32'({mem_we, bus.sob_rvalid, bus.vga_rvalid, bus.cam_err}), 32'd0);
            check("rst_mem", 32'({mem_addr, mem_wdata, bus.rdata}), 32'd0);
        end
        @(posedge clk_50);
        #1;
        rst_n = 1'b1;
        turn_sob = 1'b0;
        starve = 0;
        e_we = 1'b0;
        e_err = 1'b0;
        e_addr = '0;
        e_wdata = '0;
        e_rv1 = '0;
        e_rv2 = '0;
        e_rd1 = '0;
        e_rd2 = '0;
        tick();
        check("first_vga", 32'(dut_g), 32'd3);
        bus.cam_req = 1'b0;
        bus.sob_req = 1'b0;
        bus.vga_req = 1'b0;
        tick();

        bus.cam_req = 1'b1;
        bus.cam_addr = 15'h0010;
        bus.cam_wdata = 16'hABCD;
        tick();
        check("wr_gnt", 32'(dut_g), 32'd1);
        bus.cam_req = 1'b0;
        check("wr_we", 32'(mem_we), 32'd1);
        check("wr_addr", 32'(mem_addr), 32'h0010);
        check("wr_data", 32'(mem_wdata), 32'hABCD);

        bus.sob_req = 1'b1;
        bus.sob_addr = 15'h0010;
        tick();
        check("rb_gnt", 32'(dut_g), 32'd2);
        bus.sob_req = 1'b0;
        tick();
        check("rb_rvalid", 32'(bus.sob_rvalid), 32'd1);
        check("rb_rdata", 32'(bus.rdata), 32'hABCD);

        bus.cam_req = 1'b1;
        bus.sob_req = 1'b1;
        bus.vga_addr = 15'd100;
        for (int i = 0; i < 7; i++) begin
            bus.vga_req = (i == 2);
            tick();
            check("rr_seq", 32'(dut_g), 32'(exp_seq[i]));
            bus.cam_addr = 15'(i + 32);
            bus.cam_wdata = 16'($urandom);
            bus.sob_addr = 15'(i + 40);
        end
        bus.cam_req = 1'b0;
        bus.sob_req = 1'b0;
        bus.vga_req = 1'b0;
        tick();

        bus.cam_req = 1'b1;
        bus.cam_addr = 15'd22500;
        bus.cam_wdata = 16'h1234;
        tick();
        check("oor_gnt", 32'(dut_g), 32'd1);
        bus.cam_req = 1'b0;
        check("oor_we", 32'(mem_we), 32'd0);
        check("oor_err", 32'(bus.cam_err), 32'd1);
        bus.vga_req = 1'b1;
        bus.vga_addr = 15'd22500;
        tick();
        bus.vga_req = 1'b0;
        tick();
        check("oor_rvalid", 32'(bus.vga_rvalid), 32'd1);
        check("oor_rdata", 32'(bus.rdata), 32'd0);

        bus.vga_req = 1'b1;
        bus.sob_req = 1'b1;
        bus.sob_addr = 15'd5;
        bus.vga_addr = 15'd6;
        nsob = 0;
        first_at = -1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (dut_g == 2) begin
                nsob++;
                if (first_at < 0) first_at = i;
            end
        end
`ifdef SOB_STARVE_GUARD_EN
        check("guard_cnt", 32'(nsob), 32'd1);
        check("guard_at", 32'(first_at), 32'd15);
`else
        check("guard_cnt", 32'(nsob), 32'd0);
        check("guard_at", 32'(first_at), 32'hFFFF_FFFF);
`endif
        bus.vga_req = 1'b0;
        bus.sob_req = 1'b0;
        tick();

        repeat (600) begin
            if (!bus.cam_req || dut_g == 1) begin
                bus.cam_req = 1'($urandom_range(0, 1));
                bus.cam_addr = rand_addr();
                bus.cam_wdata = 16'($urandom);
            end
            if (!bus.sob_req || dut_g == 2) begin
                bus.sob_req = 1'($urandom_range(0, 1));
                bus.sob_addr = rand_addr();
            end
            if (!bus.vga_req || dut_g == 3) begin
                bus.vga_req = ($urandom_range(0, 3) == 0);
                bus.vga_addr = rand_addr();
            end
            tick();
        end
        bus.cam_req = 1'b0;
        bus.sob_req = 1'b0;
        bus.vga_req = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
